// File: rtl/cpu_types_pkg.sv
// Shared CPU datapath types: word width and the MEM-stage controller state encoding.
package cpu_types_pkg;

    localparam int WORD_W = 32;

    typedef logic [WORD_W-1:0] word_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } mem_state_t;

endpackage

// File: rtl/ll_link_reg.sv
// LL/SC link register: tracks the linked word, applies snoop/SC/store invalidation
// and answers whether an SC presented in the MEM stage would fail.
module ll_link_reg
    import cpu_types_pkg::*;
#(
    parameter int WORD_W = cpu_types_pkg::WORD_W
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              ll_done,
    input  logic              sc_done,
    input  logic              st_done,
    input  logic [WORD_W-1:0] done_addr,
    input  logic              snoop_valid,
    input  logic [WORD_W-1:0] snoop_addr,
    input  logic              sc_chk,
    input  logic [WORD_W-1:0] chk_addr,
    output logic              sc_fail,
    output logic              link_valid,
    output logic              link_addr_unused_lsb,
    output logic [WORD_W-1:0] link_addr
);

    logic              valid_reg, valid_next;
    logic [WORD_W-1:0] addr_reg, addr_next;
    logic              snoop_hits_link;
    logic              snoop_hits_new;
    logic              store_hits_link;

    // All address compares are word-granular; byte offset bits are ignored.
    assign snoop_hits_link = snoop_valid && (snoop_addr[WORD_W-1:2] == addr_reg[WORD_W-1:2]);
    assign snoop_hits_new  = snoop_valid && (snoop_addr[WORD_W-1:2] == done_addr[WORD_W-1:2]);
    assign store_hits_link = st_done && (done_addr[WORD_W-1:2] == addr_reg[WORD_W-1:2]);

    always_comb begin
        valid_next = valid_reg;
        addr_next  = addr_reg;
        if (ll_done) begin
            // A snoop to the word being linked in the same cycle wins over the LL.
            addr_next  = done_addr;
            valid_next = !snoop_hits_new;
        end else if (snoop_hits_link || sc_done || store_hits_link) begin
            valid_next = 1'b0;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            valid_reg <= 1'b0;
            addr_reg  <= '0;
        end else begin
            valid_reg <= valid_next;
            addr_reg  <= addr_next;
        end
    end

    assign sc_fail    = sc_chk && !(valid_reg && (addr_reg[WORD_W-1:2] == chk_addr[WORD_W-1:2]));
    assign link_valid = valid_reg;
    assign link_addr  = addr_reg;
    assign link_addr_unused_lsb = ^addr_reg[1:0];

endmodule

// File: rtl/mem_stage_ctrl.sv
// MEM-stage memory access controller: issues/holds dcache requests, stalls the
// front end while an access is outstanding and registers the load/SC result.
module mem_stage_ctrl
    import cpu_types_pkg::*;
#(
    parameter int WORD_W = cpu_types_pkg::WORD_W
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              valid_i,
    input  logic              memREN_i,
    input  logic              memWEN_i,
    input  logic              ll_i,
    input  logic              sc_i,
    input  logic [WORD_W-1:0] addr_i,
    input  logic [WORD_W-1:0] store_i,
    input  logic              hold_i,
    input  logic              dhit,
    input  logic [WORD_W-1:0] dload,
    input  logic              snoop_valid_i,
    input  logic [WORD_W-1:0] snoop_addr_i,
    output logic              dREN_o,
    output logic              dWEN_o,
    output logic [WORD_W-1:0] daddr_o,
    output logic [WORD_W-1:0] dstore_o,
    output logic              stall_o,
    output logic              done_o,
    output logic [WORD_W-1:0] dmemload_o,
    output logic              link_valid_o,
    output logic [WORD_W-1:0] link_addr_o
);

    mem_state_t        state_reg, state_next;
    logic [WORD_W-1:0] addr_reg, store_reg, result_reg;
    logic              ren_reg, wen_reg, ll_reg, sc_reg;
    logic              memop, sc_fail, capture, fail_now, hit_now;
    logic              ll_done, sc_done, st_done;
    logic              link_lsb_parity;

    assign memop    = valid_i && (memREN_i || memWEN_i);
    assign capture  = (state_reg == IDLE) && memop && !sc_fail;
    assign fail_now = (state_reg == IDLE) && memop && sc_fail;
    assign hit_now  = (state_reg == REQ) && dhit;

    assign ll_done = hit_now && ll_reg;
    assign sc_done = hit_now && sc_reg;
    assign st_done = hit_now && wen_reg && !sc_reg;

    always_comb begin
        state_next = state_reg;
        stall_o    = 1'b0;
        done_o     = 1'b0;
        dREN_o     = 1'b0;
        dWEN_o     = 1'b0;
        unique case (state_reg)
            IDLE: begin
                stall_o = memop;
                if (memop) state_next = sc_fail ? DONE : REQ;
            end
            REQ: begin
                stall_o = 1'b1;
                dREN_o  = ren_reg;
                dWEN_o  = wen_reg;
                if (dhit) state_next = DONE;
            end
            DONE: begin
                done_o  = 1'b1;
                stall_o = hold_i;
                if (!hold_i) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            addr_reg  <= '0;
            store_reg <= '0;
            ren_reg   <= 1'b0;
            wen_reg   <= 1'b0;
            ll_reg    <= 1'b0;
            sc_reg    <= 1'b0;
        end else if (capture) begin
            addr_reg  <= addr_i;
            store_reg <= store_i;
            ren_reg   <= memREN_i;
            wen_reg   <= memWEN_i;
            ll_reg    <= ll_i;
            sc_reg    <= sc_i;
        end
    end

    // Plain stores leave the previous result untouched.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            result_reg <= '0;
        end else if (fail_now) begin
            result_reg <= '0;
        end else if (hit_now && sc_reg) begin
            result_reg <= {{(WORD_W-1){1'b0}}, 1'b1};
        end else if (hit_now && ren_reg) begin
            result_reg <= dload;
        end
    end

    ll_link_reg #(.WORD_W(WORD_W)) u_link (
        .CLK                  (CLK),
        .nRST                 (nRST),
        .ll_done              (ll_done),
        .sc_done              (sc_done),
        .st_done              (st_done),
        .done_addr            (addr_reg),
        .snoop_valid          (snoop_valid_i),
        .snoop_addr           (snoop_addr_i),
        .sc_chk               (valid_i && sc_i),
        .chk_addr             (addr_i),
        .sc_fail              (sc_fail),
        .link_valid           (link_valid_o),
        .link_addr_unused_lsb (link_lsb_parity),
        .link_addr            (link_addr_o)
    );

    assign daddr_o    = addr_reg;
    assign dstore_o   = store_reg;
    assign dmemload_o = result_reg;

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Directed table-driven bench for mem_stage_ctrl plus hand sequences for reset and hold.
module tb_mem_stage_ctrl;

    logic        CLK = 1'b0;
    logic        nRST;
    logic        valid_i, memREN_i, memWEN_i, ll_i, sc_i, hold_i, dhit, snoop_valid_i;
    logic [31:0] addr_i, store_i, dload, snoop_addr_i;
    logic        dREN_o, dWEN_o, stall_o, done_o, link_valid_o;
    logic [31:0] daddr_o, dstore_o, dmemload_o, link_addr_o;

    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    mem_stage_ctrl dut (
        .CLK           (CLK),
        .nRST          (nRST),
        .valid_i       (valid_i),
        .memREN_i      (memREN_i),
        .memWEN_i      (memWEN_i),
        .ll_i          (ll_i),
        .sc_i          (sc_i),
        .addr_i        (addr_i),
        .store_i       (store_i),
        .hold_i        (hold_i),
        .dhit          (dhit),
        .dload         (dload),
        .snoop_valid_i (snoop_valid_i),
        .snoop_addr_i  (snoop_addr_i),
        .dREN_o        (dREN_o),
        .dWEN_o        (dWEN_o),
        .daddr_o       (daddr_o),
        .dstore_o      (dstore_o),
        .stall_o       (stall_o),
        .done_o        (done_o),
        .dmemload_o    (dmemload_o),
        .link_valid_o  (link_valid_o),
        .link_addr_o   (link_addr_o)
    );

    typedef struct {
        logic        ren, wen, ll, sc;
        logic [31:0] addr, store;
        int          delay;        // dhit-miss cycles before the hit
        logic [31:0] dload;
        logic        snoop_hit;    // snoop the op's own address on the dhit cycle
        logic        exp_fail;     // SC expected to fail without a cache access
        logic [31:0] exp_res;
        logic        exp_link;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic clear_inputs();
        valid_i = 0; memREN_i = 0; memWEN_i = 0; ll_i = 0; sc_i = 0;
        addr_i = 0; store_i = 0; dhit = 0; dload = 0; snoop_valid_i = 0; snoop_addr_i = 0;
    endtask

    // Entered and left at posedge+1 with the DUT in IDLE.
    task automatic run_op(input vec_t v, input string name);
        int  nren = 0, nwen = 0, nstall = 0, done_cyc = -1;
        bit  seen = 0, bus_ok = 1;
        int  exp_done_cyc = v.exp_fail ? 1 : v.delay + 2;
        valid_i = 1; memREN_i = v.ren; memWEN_i = v.wen; ll_i = v.ll; sc_i = v.sc;
        addr_i = v.addr; store_i = v.store;
        for (int cyc = 0; cyc < 20 && !seen; cyc++) begin
            if (!v.exp_fail && cyc == v.delay + 1) begin
                dhit = 1; dload = v.dload;
                snoop_valid_i = v.snoop_hit; snoop_addr_i = v.addr;
            end else begin
                dhit = 0; dload = 32'hBAD0_0000 + 32'(cyc); snoop_valid_i = 0;
            end
            #1;
            nren   += int'(dREN_o);
            nwen   += int'(dWEN_o);
            nstall += int'(stall_o);
            if ((dREN_o || dWEN_o) && daddr_o !== v.addr) bus_ok = 0;
            if (dWEN_o && dstore_o !== v.store) bus_ok = 0;
            if (done_o) begin
                seen = 1;
                done_cyc = cyc;
                check({name, " result"}, dmemload_o, v.exp_res);
                check({name, " link"}, 32'(link_valid_o), 32'(v.exp_link));
            end
            @(posedge CLK); #1;
        end
        clear_inputs();
        check({name, " done_cycle"}, 32'(done_cyc), 32'(exp_done_cyc));
        check({name, " dREN_cycles"}, 32'(nren), (v.ren && !v.exp_fail) ? 32'(v.delay + 1) : 32'd0);
        check({name, " dWEN_cycles"}, 32'(nwen), (v.wen && !v.exp_fail) ? 32'(v.delay + 1) : 32'd0);
        check({name, " stall_cycles"}, 32'(nstall), 32'(exp_done_cyc));
        check({name, " bus_stable"}, 32'(bus_ok), 32'd1);
        #1;
        check({name, " idle_after"}, {30'd0, done_o, stall_o}, 32'd0);
        $display("op %-10s addr=%h res=%h link=%b done_cyc=%0d ren=%0d wen=%0d stall=%0d",
                 name, v.addr, dmemload_o, link_valid_o, done_cyc, nren, nwen, nstall);
    endtask

    task automatic snoop_cycle(input logic [31:0] a);
        snoop_valid_i = 1; snoop_addr_i = a;
        @(posedge CLK); #1;
        snoop_valid_i = 0;
    endtask

    initial begin
        vec_t v;
        //          ren   wen   ll    sc    addr          store         dly dload         snp   fail  exp_res       link
        vecs[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0040, 32'h0,        2, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'hDEAD_BEEF, 1'b0};
        vecs[1]  = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_0080, 32'h1234_5678, 0, 32'h0,        1'b0, 1'b0, 32'hDEAD_BEEF, 1'b0};
        vecs[2]  = '{1'b1, 1'b0, 1'b1, 1'b0, 32'h0000_0100, 32'h0,        0, 32'hCAFE_0001, 1'b0, 1'b0, 32'hCAFE_0001, 1'b1};
        vecs[3]  = '{1'b0, 1'b1, 1'b0, 1'b1, 32'h0000_0100, 32'h0000_AAAA, 1, 32'h0,        1'b0, 1'b0, 32'h0000_0001, 1'b0};
        vecs[4]  = '{1'b0, 1'b1, 1'b0, 1'b1, 32'h0000_0100, 32'h0000_BBBB, 0, 32'h0,        1'b0, 1'b1, 32'h0000_0000, 1'b0};
        vecs[5]  = '{1'b1, 1'b0, 1'b1, 1'b0, 32'h0000_0200, 32'h0,        0, 32'h0000_0055, 1'b0, 1'b0, 32'h0000_0055, 1'b1};
        vecs[6]  = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_0204, 32'h0000_0011, 0, 32'h0,        1'b0, 1'b0, 32'h0000_0055, 1'b1};
        vecs[7]  = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_0203, 32'h0000_0022, 0, 32'h0,        1'b0, 1'b0, 32'h0000_0055, 1'b0};
        vecs[8]  = '{1'b1, 1'b0, 1'b1, 1'b0, 32'h0000_0300, 32'h0,        1, 32'h0000_0077, 1'b0, 1'b0, 32'h0000_0077, 1'b1};
        vecs[9]  = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0300, 32'h0,        0, 32'h0000_0088, 1'b0, 1'b0, 32'h0000_0088, 1'b1};
        vecs[10] = '{1'b0, 1'b1, 1'b0, 1'b1, 32'h0000_0302, 32'h0000_00BB, 0, 32'h0,        1'b0, 1'b0, 32'h0000_0001, 1'b0};
        vecs[11] = '{1'b1, 1'b0, 1'b1, 1'b0, 32'h0000_0100, 32'h0,        0, 32'h0000_0099, 1'b1, 1'b0, 32'h0000_0099, 1'b0};

        nRST = 0; hold_i = 0;
        clear_inputs();
        repeat (2) @(posedge CLK);
        #1;
        check("reset_ctl", {26'd0, dREN_o, dWEN_o, stall_o, done_o, link_valid_o, 1'b0}, 32'd0);
        check("reset_daddr", daddr_o, 32'd0);
        check("reset_dmemload", dmemload_o, 32'd0);
        check("reset_link_addr", link_addr_o, 32'd0);
        nRST = 1;
        @(posedge CLK); #1;

        for (int i = 0; i < 12; i++) run_op(vecs[i], $sformatf("vec%0d", i));

        // LL, then snoops to a neighbouring word and to the linked word, then SC.
        v = '{1'b1, 1'b0, 1'b1, 1'b0, 32'h100, 32'h0, 0, 32'h0000_0123, 1'b0, 1'b0, 32'h0000_0123, 1'b1};
        run_op(v, "ll_snp");
        snoop_cycle(32'h0000_0104);
        check("snoop_other_word", 32'(link_valid_o), 32'd1);
        snoop_cycle(32'h0000_0102);
        check("snoop_same_word", 32'(link_valid_o), 32'd0);
        v = '{1'b0, 1'b1, 1'b0, 1'b1, 32'h100, 32'h0000_0CCC, 0, 32'h0, 1'b0, 1'b1, 32'h0, 1'b0};
        run_op(v, "sc_snp");

        // Reset in the middle of a read request.
        v = '{1'b1, 1'b0, 1'b1, 1'b0, 32'h400, 32'h0, 0, 32'h0000_0444, 1'b0, 1'b0, 32'h0000_0444, 1'b1};
        run_op(v, "ll_rst");
        valid_i = 1; memREN_i = 1; addr_i = 32'h40;
        @(posedge CLK); #1;
        check("rst_pre_dren", 32'(dREN_o), 32'd1);
        nRST = 0;
        #1;
        check("rst_dren", 32'(dREN_o), 32'd0);
        check("rst_link", 32'(link_valid_o), 32'd0);
        check("rst_result", dmemload_o, 32'd0);
        clear_inputs();
        @(posedge CLK); #1;
        nRST = 1; dhit = 1; dload = 32'h5A5A_5A5A;
        for (int i = 0; i < 3; i++) begin
            @(posedge CLK); #1;
            check($sformatf("rst_no_done%0d", i), {30'd0, done_o, dREN_o}, 32'd0);
        end
        dhit = 0;
        $display("op rst_mid_req done=%b result=%h link=%b", done_o, dmemload_o, link_valid_o);

        // hold_i held high through three DONE cycles.
        hold_i = 1; valid_i = 1; memREN_i = 1; addr_i = 32'h40;
        #1;
        check("hold_idle_stall", 32'(stall_o), 32'd1);
        @(posedge CLK); #1;
        check("hold_req_dren", 32'(dREN_o), 32'd1);
        dhit = 1; dload = 32'h0000_1111;
        @(posedge CLK); #1;
        dhit = 0;
        for (int i = 0; i < 3; i++) begin
            dload = 32'hFFFF_0000 + 32'(i);
            #1;
            check($sformatf("hold_done%0d", i), {30'd0, done_o, stall_o}, 32'd3);
            check($sformatf("hold_data%0d", i), dmemload_o, 32'h0000_1111);
            if (i == 2) hold_i = 0;
            else begin @(posedge CLK); #1; end
        end
        #1;
        check("hold_release", {30'd0, done_o, stall_o}, 32'd2);
        @(posedge CLK); #1;
        clear_inputs();
        #1;
        check("hold_idle", {30'd0, done_o, stall_o}, 32'd0);
        check("hold_data_kept", dmemload_o, 32'h0000_1111);
        $display("op hold_done result=%h", dmemload_o);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_stage_ctrl.md
Name: mem_stage_ctrl

Overview:
- Memory-access controller for the MEM stage, between the EX/MEM pipe register and the MEM/WB pipe register.
- Issues data-cache requests for load/store/LL/SC and holds them until dhit.
- Stalls the front of the pipeline while an access is outstanding.
- Maintains the LL/SC link register with snoop invalidation, and presents the load/SC result word to the MEM/WB pipe.

Parameters:
- WORD_W, 32, datapath/address width.

Ports:
- CLK  in  1  clock
- nRST  in  1  asynchronous active-low reset
- valid_i  in  1  EX/MEM holds a live instruction
- memREN_i  in  1  load (includes LL)
- memWEN_i  in  1  store (includes SC)
- ll_i  in  1  instruction is LL
- sc_i  in  1  instruction is SC
- addr_i  in  WORD_W  effective address (EX/MEM aluout)
- store_i  in  WORD_W  store data
- hold_i  in  1  stall from other hazard sources (pipeline frozen)
- dhit  in  1  cache access complete
- dload  in  WORD_W  cache read data
- snoop_valid_i  in  1  coherence invalidate observed
- snoop_addr_i  in  WORD_W  invalidated address
- dREN_o  out  1  cache read request
- dWEN_o  out  1  cache write request
- daddr_o  out  WORD_W  cache address
- dstore_o  out  WORD_W  cache write data
- stall_o  out  1  freeze PC/IF_ID/ID_EX/EX_MEM
- done_o  out  1  result valid for MEM/WB capture
- dmemload_o  out  WORD_W  load data, or SC result (1 = success, 0 = fail)
- link_valid_o  out  1  link register valid
- link_addr_o  out  WORD_W  linked address

Behaviour:
- Reset (async, nRST low):
  - state = IDLE; all outputs 0; link cleared; captured regs 0.
  - dREN_o/dWEN_o drop immediately, including mid-access; an outstanding dhit after reset is ignored.
- memop = valid_i & (memREN_i | memWEN_i).
- sc_fail = sc_i & !(link_valid & link_addr[31:2] == addr_i[31:2]). Word-aligned compare; bits [1:0] ignored.
- States:
  - IDLE:
    - memop & !sc_fail: capture addr/store/REN/WEN/ll/sc; next REQ.
    - memop & sc_fail: no cache write; result <= 0; next DONE.
    - otherwise: stay.
  - REQ:
    - dREN_o/dWEN_o/daddr_o/dstore_o driven from captured regs, held stable until dhit.
    - On dhit: result <= dload for loads, 1 for SC; next DONE.
  - DONE:
    - done_o = 1.
    - Stay while hold_i; else next IDLE.
- stall_o = (IDLE & memop) | REQ | (DONE & hold_i). Combinational.
  - Latency: minimum 3 cycles IDLE->REQ->DONE with dhit in the first REQ cycle; +1 cycle per dhit-miss cycle.
- dmemload_o is registered and holds its value until the next result is written.
- Link register, evaluated at the dhit edge, highest priority first:
  1. Snoop: snoop_valid_i with a word match to link_addr clears the link. Snoop beats an LL completing in the same cycle.
  2. LL completion: sets link_valid, link_addr = captured addr.
  3. SC success: clears the link.
  4. Plain store completion whose word matches link_addr: clears the link.
  - Snoop is evaluated every cycle, in any state.
- A failed SC never asserts dWEN_o. A successful SC writes exactly once.
- hold_i in IDLE/REQ does not suppress requests; only DONE waits on hold_i.
- Non-memory instructions pass with stall_o = 0 and done_o = 0; MEM/WB then uses aluout.

Decomposition:
- cpu_types_pkg:
  - mem_state_t enum {IDLE, REQ, DONE}
  - WORD_W / word_t reuse
- Sub-module ll_link_reg: owns link_valid/link_addr, the priority rules above, and the sc_fail compare.
- Top module: FSM, request drivers, result register.

Test Plan:
- Load, addr 0x0000_0040, dhit low for 2 cycles then dload 0xDEAD_BEEF → dREN_o high 3 cycles; stall_o high through REQ; done_o one cycle; dmemload_o = 0xDEAD_BEEF.
- Store 0x1234_5678 to 0x80 with dhit in the first REQ cycle → dWEN_o exactly 1 cycle; daddr_o = 0x80, dstore_o = 0x1234_5678; dREN_o never high.
- LL 0x100, then SC 0x100 → link_valid_o = 1 after LL; SC writes; dmemload_o = 1; link_valid_o = 0 after SC.
- LL 0x100, snoop 0x104 (no effect), snoop 0x102 (clears), SC 0x100 → no dWEN_o; dmemload_o = 0; stall_o for only 1 cycle.
- Snoop to 0x100 in the same cycle as the LL 0x100 dhit → link_valid_o = 0.
- nRST low while in REQ with dREN_o asserted → dREN_o = 0 immediately; state IDLE; link cleared. dhit the next cycle yields no done_o.
- hold_i high in DONE for 3 cycles → done_o and stall_o stay high; dmemload_o stable; IDLE follows the cycle after hold_i falls.
